vx_commit_arb: RTL and testbench
================================

Name: vx_commit_arb

Overview:
Per-issue-slice commit arbiter sitting directly downstream of the execute stage. It gathers the commit streams of all execution units (ALU, LSU, FPU, TCU, SFU) for one issue slice and merges them into a single registered writeback/commit stream. Multi-beat commits stay atomic: once a unit is granted, it holds the output until its last beat. The block also counts retired instructions.

Parameters:
NUM_UNITS, 4, number of execution-unit commit inputs (≥1)
DATAW, 64, commit payload width per beat (wid, PC, rd, data, tmask packed by caller)
CNTW, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  NUM_UNITS  per-unit commit beat valid
in_data  in  NUM_UNITS*DATAW  per-unit payload; unit i at [i*DATAW +: DATAW]
in_eop  in  NUM_UNITS  per-unit last-beat-of-instruction flag
in_ready  out  NUM_UNITS  per-unit accept
out_valid  out  1  merged commit valid
out_data  out  DATAW  merged payload
out_eop  out  1  last beat of instruction
out_sel  out  max(1,$clog2(NUM_UNITS))  index of the source unit
out_ready  in  1  downstream (writeback/scoreboard) accept
retired_cnt  out  CNTW  instructions retired (eop beats delivered)

Behaviour:
- Handshake: a beat transfers when valid && ready, on both sides. Once in_valid is asserted, in_data/in_eop must hold until accepted. out_* obeys the same rule.
- Arbitration: round-robin, combinational grant among in_valid.
  - Priority pointer rr_ptr starts at unit 0.
  - After an accepted input beat with in_eop=1 from unit g, rr_ptr ← (g+1) mod NUM_UNITS. Otherwise rr_ptr is unchanged.
- Lock: an accepted beat with in_eop=0 from unit g sets lock=1, lock_id=g. While locked, only unit g may be granted, even if other units are valid. Lock clears when unit g's eop beat is accepted.
- in_ready[i] = grant[i] && skid buffer not full. At most one in_ready bit is high per cycle.
- Output stage: 2-entry skid buffer.
  - out_valid/out_data/out_eop/out_sel are driven from registers only. No combinational path from in_* to out_*, or from out_ready to in_ready.
  - Latency: input accept at cycle N → out_valid at N+1.
  - Sustained throughput: 1 beat/cycle when out_ready=1.
- Buffer full (2 entries): all in_ready=0.
- Buffer empty: out_valid=0.
- Simultaneous push and pop on a 1-entry buffer: occupancy stays 1 and order is preserved (FIFO).
- retired_cnt increments by 1 on each out_valid && out_ready && out_eop. Wraps modulo 2^CNTW, no saturation.
- NUM_UNITS=1: arbiter degenerates to pass-through into the skid buffer. out_sel is constant 0.
- Reset (any cycle, including mid-packet):
  - Buffer emptied, out_valid=0, out_data=0, out_eop=0, out_sel=0.
  - rr_ptr=0, lock=0, retired_cnt=0, in_ready=0 during reset.
  - In-flight beats are discarded; upstream units are reset together with this block.

Optional Feature:
VX_COMMIT_ARB_PERF_EN: adds output ports perf_stall_cnt (CNTW) and perf_lock_cnt (CNTW).
- perf_stall_cnt increments each cycle where |in_valid && no input beat is accepted.
- perf_lock_cnt increments each cycle where lock=1 && some unit other than lock_id is valid.
- Both counters reset to 0 and wrap.
- Without the macro: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Single unit: in_valid[2]=1, eop=1, data=0xA5 with out_ready=1 → out_valid at next cycle, out_data=0xA5, out_sel=2, retired_cnt 0→1.
- Fairness: all 4 units continuously valid, single-beat, out_ready=1 → out_sel sequence 0,1,2,3,0,… and 1 beat/cycle.
- Lock: unit 1 sends 3 beats (eop on 3rd) while unit 0 is valid throughout → out_sel=1,1,1 then 0; unit 0's in_ready=0 for those 3 cycles.
- Backpressure: out_ready=0 with unit 3 streaming → exactly 2 beats accepted, then in_ready=0. Raising out_ready releases the beats in order with no loss or duplication.
- Reset mid-packet: assert reset after beat 1 of a 3-beat packet → next cycle out_valid=0, lock cleared, retired_cnt=0, and a fresh unit-0 request is granted first.
- Counter wrap (CNTW=4): 17 eop beats → retired_cnt=1. With VX_COMMIT_ARB_PERF_EN, 5 cycles of out_ready=0 after the buffer fills → perf_stall_cnt=5.

Source files
------------

// File: rtl/vx_commit_arb.sv
// vx_commit_arb: per-issue-slice commit arbiter.
// Merges NUM_UNITS execution-unit commit streams into one registered stream through a
// 2-entry skid buffer. Round-robin grant with multi-beat lock, plus a retired-instruction
// counter. Define VX_COMMIT_ARB_PERF_EN to add the stall/lock performance counters.
module vx_commit_arb #(
   parameter int unsigned NUM_UNITS = 4,
   parameter int unsigned DATAW     = 64,
   parameter int unsigned CNTW      = 32,
   localparam int unsigned SELW     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [NUM_UNITS-1:0]       in_valid_i,
   input  logic [NUM_UNITS*DATAW-1:0] in_data_i,
   input  logic [NUM_UNITS-1:0]       in_eop_i,
   output logic [NUM_UNITS-1:0]       in_ready_o,
   output logic                       out_valid_o,
   output logic [DATAW-1:0]           out_data_o,
   output logic                       out_eop_o,
   output logic [SELW-1:0]            out_sel_o,
   input  logic                       out_ready_i,
`ifdef VX_COMMIT_ARB_PERF_EN
   output logic [CNTW-1:0]            perf_stall_cnt_o,
   output logic [CNTW-1:0]            perf_lock_cnt_o,
`endif
   output logic [CNTW-1:0]            retired_cnt_o
);

   // Buffer entry: {sel, eop, data}
   localparam int unsigned BW = SELW + 1 + DATAW;

   logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
   logic            lock_q, lock_d;
   logic [SELW-1:0] lock_id_q, lock_id_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [BW-1:0]   head_q, head_d;
   logic [BW-1:0]   tail_q, tail_d;
   logic [CNTW-1:0] retired_q, retired_d;

   logic             gnt_valid;
   logic [SELW-1:0]  gnt_id;
   logic [DATAW-1:0] gnt_data;
   logic             gnt_eop;
   logic             full;
   logic             accept;
   logic             pop;
   logic [BW-1:0]    in_beat;

   // Grant: locked owner only, otherwise first valid unit starting at rr_ptr.
   always_comb begin
      int idx;
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = 0;
      if (lock_q) begin
         for (int i = 0; i < int'(NUM_UNITS); i++) begin
            if (SELW'(i) == lock_id_q && in_valid_i[i]) begin
               gnt_valid = 1'b1;
               gnt_id    = SELW'(i);
            end
         end
      end else begin
         // Walk backwards so the closest unit to rr_ptr wins.
         for (int k = int'(NUM_UNITS) - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % int'(NUM_UNITS);
            if (in_valid_i[idx]) begin
               gnt_valid = 1'b1;
               gnt_id    = SELW'(idx);
            end
         end
      end
   end

   // Mux the granted unit's payload.
   always_comb begin
      gnt_data = '0;
      gnt_eop  = 1'b0;
      for (int i = 0; i < int'(NUM_UNITS); i++) begin
         if (gnt_id == SELW'(i)) begin
            gnt_data = in_data_i[i*DATAW +: DATAW];
            gnt_eop  = in_eop_i[i];
         end
      end
   end

   assign full    = (cnt_q == 2'd2);
   assign accept  = gnt_valid && !full && !reset_i;
   assign pop     = (cnt_q != 2'd0) && out_ready_i;
   assign in_beat = {gnt_id, gnt_eop, gnt_data};

   // Ready only to the granted unit; depends on occupancy, never on out_ready.
   always_comb begin
      for (int i = 0; i < int'(NUM_UNITS); i++) begin
         in_ready_o[i] = gnt_valid && (gnt_id == SELW'(i)) && !full && !reset_i;
      end
   end

   // Arbiter pointer and lock next-state.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (accept) begin
         lock_d    = !gnt_eop;
         lock_id_d = gnt_id;
         if (gnt_eop) begin
            rr_ptr_d = (gnt_id == SELW'(NUM_UNITS - 1)) ? '0 : gnt_id + 1'b1;
         end
      end
   end

   // Skid buffer next-state: head feeds the output, tail only fills when head is stalled.
   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      case (cnt_q)
         2'd0: begin
            if (accept) begin
               head_d = in_beat;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (accept && pop) begin
               head_d = in_beat;
            end else if (pop) begin
               cnt_d = 2'd0;
            end else if (accept) begin
               tail_d = in_beat;
               cnt_d  = 2'd2;
            end
         end
         2'd2: begin
            if (pop) begin
               head_d = tail_q;
               cnt_d  = 2'd1;
            end
         end
         default: cnt_d = 2'd0;
      endcase
   end

   // Retired count advances on each delivered last beat; wraps naturally.
   always_comb begin
      retired_d = retired_q;
      if (pop && head_q[DATAW]) begin
         retired_d = retired_q + CNTW'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         cnt_q     <= 2'd0;
         head_q    <= '0;
         tail_q    <= '0;
         retired_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         cnt_q     <= cnt_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         retired_q <= retired_d;
      end
   end

   assign out_valid_o   = (cnt_q != 2'd0);
   assign out_data_o    = head_q[DATAW-1:0];
   assign out_eop_o     = head_q[DATAW];
   assign out_sel_o     = head_q[BW-1 -: SELW];
   assign retired_cnt_o = retired_q;

`ifdef VX_COMMIT_ARB_PERF_EN
   logic [CNTW-1:0] perf_stall_q;
   logic [CNTW-1:0] perf_lock_q;
   logic            other_valid;

   // Any unit other than the lock owner requesting.
   always_comb begin
      other_valid = 1'b0;
      for (int i = 0; i < int'(NUM_UNITS); i++) begin
         if (in_valid_i[i] && SELW'(i) != lock_id_q) begin
            other_valid = 1'b1;
         end
      end
   end

   // Stall and lock-contention counters.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         perf_stall_q <= '0;
         perf_lock_q  <= '0;
      end else begin
         if (|in_valid_i && !accept) begin
            perf_stall_q <= perf_stall_q + CNTW'(1);
         end
         if (lock_q && other_valid) begin
            perf_lock_q <= perf_lock_q + CNTW'(1);
         end
      end
   end

   assign perf_stall_cnt_o = perf_stall_q;
   assign perf_lock_cnt_o  = perf_lock_q;
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Scoreboard bench for vx_commit_arb (4 units, 16-bit payload, 4-bit counters so wrap is
// reachable). Expected beats come from an abstract model: per-unit packet queues, an owner
// lock, a round-robin start index and a 2-deep occupancy count.
module tb_vx_commit_arb;

   localparam int NU = 4;
   localparam int DW = 16;
   localparam int CW = 4;
   localparam int SW = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [NU-1:0]    in_valid;
   logic [NU*DW-1:0] in_data;
   logic [NU-1:0]    in_eop;
   logic [NU-1:0]    in_ready;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic             out_eop;
   logic [SW-1:0]    out_sel;
   logic             out_ready;
   logic [CW-1:0]    retired_cnt;
`ifdef VX_COMMIT_ARB_PERF_EN
   logic [CW-1:0]    perf_stall_cnt;
   logic [CW-1:0]    perf_lock_cnt;
`endif

   vx_commit_arb #(.NUM_UNITS(NU), .DATAW(DW), .CNTW(CW)) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .in_valid_i       (in_valid),
      .in_data_i        (in_data),
      .in_eop_i         (in_eop),
      .in_ready_o       (in_ready),
      .out_valid_o      (out_valid),
      .out_data_o       (out_data),
      .out_eop_o        (out_eop),
      .out_sel_o        (out_sel),
      .out_ready_i      (out_ready),
`ifdef VX_COMMIT_ARB_PERF_EN
      .perf_stall_cnt_o (perf_stall_cnt),
      .perf_lock_cnt_o  (perf_lock_cnt),
`endif
      .retired_cnt_o    (retired_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Stimulus: per-unit queues of {eop, data} beats.
   logic [DW:0]      uq[NU][$];
   bit               pend[NU];
   // Expected output beats {sel, eop, data}.
   logic [SW+DW:0]   sb[$];
   // Model state.
   bit               m_lock;
   int               m_owner;
   int               m_next;
   int               occ;
   int               occ_now;
   logic [CW-1:0]    exp_ret;
   logic [CW-1:0]    m_stall;
   logic [CW-1:0]    m_lockc;
   bit               in_rst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_pkt(input int u, input int len);
      for (int b = 0; b < len; b++) begin
         logic [DW-1:0] d;
         d = DW'($urandom);
         uq[u].push_back({(b == len - 1), d});
      end
   endtask

   function automatic bit all_idle();
      bit idle;
      idle = (sb.size() == 0) && (occ == 0);
      for (int u = 0; u < NU; u++) if (uq[u].size() != 0 || pend[u]) idle = 1'b0;
      return idle;
   endfunction

   // One clock of stimulus plus the model's view of what the DUT must accept.
   task automatic cycle(input int ready_pct, input int offer_pct);
      int  g;
      bit  acc;
      bit  popm;
      bit  other;
      logic [NU-1:0] exp_rdy;
      logic [DW:0]   beat;
      @(posedge clk);
      #1;
`ifdef VX_COMMIT_ARB_PERF_EN
      chk("perf_stall", 32'(perf_stall_cnt), 32'(m_stall));
      chk("perf_lock", 32'(perf_lock_cnt), 32'(m_lockc));
`endif
      for (int u = 0; u < NU; u++) begin
         if (!pend[u] && uq[u].size() != 0 && $urandom_range(99) < offer_pct) pend[u] = 1'b1;
         in_valid[u] = pend[u];
         if (pend[u]) begin
            in_data[u*DW +: DW] = uq[u][0][DW-1:0];
            in_eop[u]           = uq[u][0][DW];
         end else begin
            in_data[u*DW +: DW] = DW'($urandom);
            in_eop[u]           = 1'($urandom);
         end
      end
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      // Owner keeps the output; otherwise the first requester from m_next onward.
      g = -1;
      if (m_lock) begin
         if (pend[m_owner]) g = m_owner;
      end else begin
         for (int k = 0; k < NU; k++) begin
            if (g < 0 && pend[(m_next + k) % NU]) g = (m_next + k) % NU;
         end
      end
      exp_rdy = (g >= 0 && occ < 2) ? NU'(1 << g) : '0;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc  = (exp_rdy != 0);
      popm = (occ > 0) && out_ready;
      other = 1'b0;
      for (int u = 0; u < NU; u++) if (pend[u] && u != m_owner) other = 1'b1;
      if ((pend[0] || pend[1] || pend[2] || pend[3]) && !acc) m_stall = m_stall + 1'b1;
      if (m_lock && other) m_lockc = m_lockc + 1'b1;
      occ_now = occ;
      if (acc) begin
         beat = uq[g].pop_front();
         sb.push_back({SW'(g), beat});
         pend[g] = 1'b0;
         if (beat[DW]) begin
            m_lock = 1'b0;
            m_next = (g + 1) % NU;
         end else begin
            m_lock  = 1'b1;
            m_owner = g;
         end
      end
      occ = occ + int'(acc) - int'(popm);
   endtask

   // Monitor: output side of the scoreboard.
   always @(negedge clk) begin
      logic [SW+DW:0] e;
      if (!in_rst) begin
         chk("retired_cnt", 32'(retired_cnt), 32'(exp_ret));
         chk("out_valid", 32'(out_valid), 32'(occ_now > 0));
         if (occ_now > 0) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               e = sb[0];
               chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
               chk("out_eop", 32'(out_eop), 32'(e[DW]));
               chk("out_sel", 32'(out_sel), 32'(e[SW+DW:DW+1]));
               if (out_ready) begin
                  void'(sb.pop_front());
                  if (e[DW]) exp_ret = exp_ret + 1'b1;
               end
            end
         end
      end
   end

   task automatic clear_model();
      sb.delete();
      for (int u = 0; u < NU; u++) begin
         uq[u].delete();
         pend[u] = 1'b0;
      end
      m_lock = 1'b0; m_owner = 0; m_next = 0;
      occ = 0; occ_now = 0;
      exp_ret = '0; m_stall = '0; m_lockc = '0;
   endtask

   // Reset with all units requesting: ready must stay low and outputs must clear.
   task automatic do_reset();
      @(posedge clk);
      #1;
      in_rst    = 1'b1;
      reset     = 1'b1;
      in_valid  = '1;
      in_eop    = '0;
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_eop", 32'(out_eop), 32'd0);
      chk("rst_out_sel", 32'(out_sel), 32'd0);
      chk("rst_retired", 32'(retired_cnt), 32'd0);
      reset    = 1'b0;
      in_valid = '0;
      clear_model();
      in_rst   = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!all_idle() && n < 400) begin
         cycle(100, 100);
         n++;
      end
      if (!all_idle()) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending beats expected 0", sb.size());
      end
      cycle(100, 100);
   endtask

   initial begin
      in_rst    = 1'b1;
      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      in_eop    = '0;
      out_ready = 1'b0;
      clear_model();
      do_reset();

      // Single unit 2 beat.
      uq[2].push_back({1'b1, 16'h00A5});
      drain();
      chk("single_retired", 32'(retired_cnt), 32'd1);

      // Move the pointer to unit 1, then lock by unit 1 while unit 0 waits.
      add_pkt(0, 1);
      drain();
      add_pkt(1, 3);
      add_pkt(0, 1);
      add_pkt(0, 1);
      drain();

      // Fairness with every unit always requesting.
      for (int u = 0; u < NU; u++) for (int p = 0; p < 4; p++) add_pkt(u, 1);
      drain();

      // Backpressure: unit 3 streams into a stalled output.
      for (int p = 0; p < 6; p++) add_pkt(3, 1);
      for (int c = 0; c < 7; c++) cycle(0, 100);
      drain();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         for (int u = 0; u < NU; u++) begin
            if (uq[u].size() < 4 && $urandom_range(99) < 30) add_pkt(u, $urandom_range(1, 3));
         end
         cycle(70, 60);
      end
      drain();

      // Reset in the middle of a 3-beat packet, then a fresh unit-0 request.
      add_pkt(1, 3);
      cycle(100, 100);
      cycle(100, 100);
      do_reset();
      add_pkt(3, 1);
      add_pkt(0, 1);
      drain();

      // Counter wrap: 17 last beats on a 4-bit counter.
      do_reset();
      for (int p = 0; p < 17; p++) add_pkt(p % NU, 1);
      drain();
      chk("retired_wrap", 32'(retired_cnt), 32'd1);

      // Stall cycles once the buffer is full.
      do_reset();
      for (int p = 0; p < 8; p++) add_pkt(2, 1);
      for (int c = 0; c < 7; c++) cycle(0, 100);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit.
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "time limit");
   end

endmodule
